// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants shared by sync generator, renderer and game logic
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  localparam logic SYNC_POL_DEF = 1'b0;

  function automatic int timing_total(input int active, input int front,
                                      input int sync_w, input int back);
    return active + front + sync_w + back;
  endfunction

  localparam int H_TOTAL_DEF = timing_total(H_ACTIVE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = timing_total(V_ACTIVE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - DEPTH-stage shift register with a reset value; DEPTH=0 is a wire
module sync_delay_line #(
  parameter int   DEPTH   = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
      assign dout = din;
    end else begin : g_pipe
      logic [DEPTH-1:0] stage;

      always_ff @(posedge clk) begin
        if (!reset) begin
          stage <= {DEPTH{RST_VAL}};
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing: pixel tick, x/y counters, sync pulses, strobes
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FRONT  = H_FRONT_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BACK   = H_BACK_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FRONT  = V_FRONT_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BACK   = V_BACK_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF,
  parameter int   PIPE_DLY = 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               hsync_d,
  output logic               vsync_d,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [3:0]         DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);

  // One extra bit so a sync window ending exactly at 1024 still compares correctly
  localparam logic [COORD_W:0] H_ACT_END  = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COORD_W:0] H_SYNC_BEG = (COORD_W+1)'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_W:0] H_SYNC_END = (COORD_W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_W:0] V_ACT_END  = (COORD_W+1)'(V_ACTIVE);
  localparam logic [COORD_W:0] V_SYNC_BEG = (COORD_W+1)'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_W:0] V_SYNC_END = (COORD_W+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL or V_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_sync_gen: CLK_DIV must be 1..16");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
      $error("vga_sync_gen: PIPE_DLY must be 0..4");
    end
  endgenerate

  logic [3:0]         div_cnt;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               run;
  logic               h_wrap;
  logic               v_wrap;
  logic               h_in_sync;
  logic               v_in_sync;

  assign p_tick = run && (div_cnt == DIV_LAST);
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        div_cnt <= p_tick ? 4'd0 : div_cnt + 4'd1;
        if (p_tick) begin
          h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
          if (h_wrap) begin
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Everything below decodes registered state, so x/y/video_on/syncs agree in every clk
  assign h_in_sync = ({1'b0, h_cnt} >= H_SYNC_BEG) && ({1'b0, h_cnt} < H_SYNC_END);
  assign v_in_sync = ({1'b0, v_cnt} >= V_SYNC_BEG) && ({1'b0, v_cnt} < V_SYNC_END);

  assign x           = run ? h_cnt : '0;
  assign y           = run ? v_cnt : '0;
  assign video_on    = run && ({1'b0, h_cnt} < H_ACT_END) && ({1'b0, v_cnt} < V_ACT_END);
  assign hsync       = (run && h_in_sync) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = (run && v_in_sync) ? SYNC_POL : ~SYNC_POL;
  assign line_start  = p_tick && h_wrap;
  assign frame_start = line_start && v_wrap;

  sync_delay_line #(
    .DEPTH   (PIPE_DLY),
    .RST_VAL (~SYNC_POL)
  ) u_hsync_dly (
    .clk   (clk),
    .reset (reset),
    .din   (hsync),
    .dout  (hsync_d)
  );

  sync_delay_line #(
    .DEPTH   (PIPE_DLY),
    .RST_VAL (~SYNC_POL)
  ) u_vsync_dly (
    .clk   (clk),
    .reset (reset),
    .din   (vsync),
    .dout  (vsync_d)
  );

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed bench: default timing, a shrunken frame, and a CLK_DIV=1 active-high build
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic       d_p_tick, d_video_on, d_hsync, d_vsync, d_hsync_d, d_vsync_d, d_line_start, d_frame_start;
  logic [9:0] d_x, d_y;
  logic       s_p_tick, s_video_on, s_hsync, s_vsync, s_hsync_d, s_vsync_d, s_line_start, s_frame_start;
  logic [9:0] s_x, s_y;
  logic       f_p_tick, f_video_on, f_hsync, f_vsync, f_hsync_d, f_vsync_d, f_line_start, f_frame_start;
  logic [9:0] f_x, f_y;

  vga_sync_gen u_def (
    .clk(clk), .reset(reset), .p_tick(d_p_tick), .x(d_x), .y(d_y), .video_on(d_video_on),
    .hsync(d_hsync), .vsync(d_vsync), .hsync_d(d_hsync_d), .vsync_d(d_vsync_d),
    .line_start(d_line_start), .frame_start(d_frame_start)
  );

  // 15x10 raster at CLK_DIV=2: a whole frame is 300 clks
  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0), .PIPE_DLY(1)
  ) u_small (
    .clk(clk), .reset(reset), .p_tick(s_p_tick), .x(s_x), .y(s_y), .video_on(s_video_on),
    .hsync(s_hsync), .vsync(s_vsync), .hsync_d(s_hsync_d), .vsync_d(s_vsync_d),
    .line_start(s_line_start), .frame_start(s_frame_start)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .SYNC_POL(1'b1), .PIPE_DLY(0)
  ) u_fast (
    .clk(clk), .reset(reset), .p_tick(f_p_tick), .x(f_x), .y(f_y), .video_on(f_video_on),
    .hsync(f_hsync), .vsync(f_vsync), .hsync_d(f_hsync_d), .vsync_d(f_vsync_d),
    .line_start(f_line_start), .frame_start(f_frame_start)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({d_x, d_y} !== 20'd0)
      $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", d_x, d_y);
    checks++;
    if ({d_video_on, d_p_tick, d_hsync, d_vsync, d_hsync_d, d_vsync_d, d_line_start, d_frame_start} !== 8'b0011_1100)
      $display("FAIL reset_flags: got %b expected 00111100",
               {d_video_on, d_p_tick, d_hsync, d_vsync, d_hsync_d, d_vsync_d, d_line_start, d_frame_start});
    checks++;
    if ({f_p_tick, f_hsync, f_vsync, f_hsync_d} !== 4'b0000)
      $display("FAIL reset_fast_idle: got %b expected 0000", {f_p_tick, f_hsync, f_vsync, f_hsync_d});
    reset = 1'b1;
    tick();
    checks++;
    if ({d_video_on, d_hsync, d_vsync, d_x, d_y} !== {3'b111, 20'd0})
      $display("FAIL release_cycle0: got von=%b hs=%b vs=%b x=%0d y=%0d expected 1 1 1 0 0",
               d_video_on, d_hsync, d_vsync, d_x, d_y);
    checks++;
    if (f_p_tick !== 1'b1)
      $display("FAIL release_fast_tick: got %b expected 1", f_p_tick);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (d_p_tick !== 1'(c == 3))
        $display("FAIL release_p_tick: cycle %0d got %b expected %b", c, d_p_tick, 1'(c == 3));
      checks++;
      if (d_x !== ((c == 4) ? 10'd1 : 10'd0))
        $display("FAIL release_x: cycle %0d got %0d expected %0d", c, d_x, (c == 4) ? 1 : 0);
      tick();
    end
    errors += 0;
  endtask

  task automatic test_line();
    int bad = 0, first_bad = -1, hs_ticks = 0, ls_cnt = 0, ls_cyc = -1, fall_x = -1;
    logic [9:0] end_x = '1, end_y = '1;
    restart();
    for (int cyc = 0; cyc <= 3200; cyc++) begin
      int p, ex, ey;
      logic e_tick, e_von, e_hs, e_ls;
      p = cyc / 4; ex = p % 800; ey = p / 800;
      e_tick = (cyc % 4) == 3;
      e_von  = (ex < 640) && (ey < 480);
      e_hs   = !((ex >= 656) && (ex < 752));
      e_ls   = e_tick && (ex == 799);
      if ({d_x, d_y, d_p_tick, d_video_on, d_hsync, d_vsync, d_line_start, d_frame_start} !==
          {10'(ex), 10'(ey), e_tick, e_von, e_hs, 1'b1, e_ls, 1'b0}) begin
        bad++;
        if (first_bad < 0) first_bad = cyc;
      end
      if (d_p_tick && !d_hsync) hs_ticks++;
      if (d_line_start) begin ls_cnt++; ls_cyc = cyc; end
      if (!d_video_on && fall_x < 0) fall_x = d_x;
      if (cyc == 3200) begin end_x = d_x; end_y = d_y; end
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL line_model: got %0d bad cycles (first at %0d) expected 0", bad, first_bad);
    end
    checks++;
    if (hs_ticks !== 96) begin errors++; $display("FAIL line_hsync_width: got %0d expected 96", hs_ticks); end
    checks++;
    if (ls_cnt !== 1 || ls_cyc !== 3199) begin
      errors++;
      $display("FAIL line_start: got count=%0d at cycle %0d expected 1 at 3199", ls_cnt, ls_cyc);
    end
    checks++;
    if (fall_x !== 640) begin errors++; $display("FAIL video_on_fall: got x=%0d expected 640", fall_x); end
    checks++;
    if ({end_x, end_y} !== {10'd0, 10'd1}) begin
      errors++;
      $display("FAIL next_line: got x=%0d y=%0d expected 0 1", end_x, end_y);
    end
  endtask

  task automatic test_frame();
    int bad = 0, first_bad = -1, dly_bad = 0, vs_ticks = 0, fs_cnt = 0, fs_first = -1, fs_last = -1, after_bad = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1, prev_fs = 1'b0;
    restart();
    for (int cyc = 0; cyc < 620; cyc++) begin
      int p, ex, ey;
      logic e_tick, e_von, e_hs, e_vs, e_ls, e_fs;
      p = cyc / 2; ex = p % 15; ey = (p / 15) % 10;
      e_tick = (cyc % 2) == 1;
      e_von  = (ex < 8) && (ey < 6);
      e_hs   = !((ex >= 10) && (ex < 13));
      e_vs   = !((ey >= 7) && (ey < 9));
      e_ls   = e_tick && (ex == 14);
      e_fs   = e_ls && (ey == 9);
      if ({s_x, s_y, s_p_tick, s_video_on, s_hsync, s_vsync, s_line_start, s_frame_start} !==
          {10'(ex), 10'(ey), e_tick, e_von, e_hs, e_vs, e_ls, e_fs}) begin
        bad++;
        if (first_bad < 0) first_bad = cyc;
      end
      if (s_hsync_d !== prev_hs || s_vsync_d !== prev_vs) dly_bad++;
      if (prev_fs && {s_x, s_y} !== 20'd0) after_bad++;
      if (s_p_tick && !s_vsync) vs_ticks++;
      if (s_frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = cyc;
        fs_last = cyc;
      end
      prev_hs = s_hsync; prev_vs = s_vsync; prev_fs = s_frame_start;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL frame_model: got %0d bad cycles (first at %0d) expected 0", bad, first_bad);
    end
    checks++;
    if (dly_bad !== 0) begin errors++; $display("FAIL sync_delay_1: got %0d bad cycles expected 0", dly_bad); end
    checks++;
    if (vs_ticks !== 60) begin errors++; $display("FAIL vsync_width: got %0d ticks expected 60", vs_ticks); end
    checks++;
    if (fs_cnt !== 2 || fs_first !== 299 || fs_last !== 599) begin
      errors++;
      $display("FAIL frame_start: got count=%0d first=%0d last=%0d expected 2 299 599", fs_cnt, fs_first, fs_last);
    end
    checks++;
    if (after_bad !== 0) begin errors++; $display("FAIL frame_wrap_xy: got %0d bad expected 0", after_bad); end
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    restart();
    repeat (2800) tick();
    checks++;
    if (d_x !== 10'd700 || d_hsync !== 1'b0 || d_hsync_d !== 1'b0) begin
      errors++;
      $display("FAIL mid_precondition: got x=%0d hs=%b hsd=%b expected 700 0 0", d_x, d_hsync, d_hsync_d);
    end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if ({d_x, d_y} !== 20'd0 ||
          {d_video_on, d_p_tick, d_hsync, d_vsync, d_hsync_d, d_vsync_d, d_line_start, d_frame_start} !== 8'b0011_1100 ||
          {f_p_tick, f_line_start, f_hsync, f_hsync_d, f_x} !== 14'd0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL mid_reset_outputs: got %0d bad cycles expected 0", bad); end
    reset = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({d_p_tick, d_x} !== {1'(c == 3), (c == 4) ? 10'd1 : 10'd0}) begin
        errors++;
        $display("FAIL mid_restart: cycle %0d got p_tick=%b x=%0d expected %b %0d",
                 c, d_p_tick, d_x, 1'(c == 3), (c == 4) ? 1 : 0);
      end
      tick();
    end
  endtask

  task automatic test_fast();
    int bad = 0, first_bad = -1, hs_cnt = 0, ls_cyc = -1;
    restart();
    for (int cyc = 0; cyc <= 800; cyc++) begin
      int ex, ey;
      logic e_hs;
      ex = cyc % 800; ey = cyc / 800;
      e_hs = (ex >= 656) && (ex < 752);
      if ({f_x, f_y, f_p_tick, f_video_on, f_hsync, f_hsync_d, f_vsync, f_vsync_d, f_line_start} !==
          {10'(ex), 10'(ey), 1'b1, 1'(ex < 640), e_hs, e_hs, 1'b0, 1'b0, 1'(ex == 799)}) begin
        bad++;
        if (first_bad < 0) first_bad = cyc;
      end
      if (f_hsync) hs_cnt++;
      if (f_line_start) ls_cyc = cyc;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL fast_model: got %0d bad cycles (first at %0d) expected 0", bad, first_bad);
    end
    checks++;
    if (hs_cnt !== 96) begin errors++; $display("FAIL fast_hsync_width: got %0d expected 96", hs_cnt); end
    checks++;
    if (ls_cyc !== 799) begin errors++; $display("FAIL fast_line_start: got cycle %0d expected 799", ls_cyc); end
  endtask

  // test_reset prints its own FAILs; tally them from the same conditions it checks
  int reset_fail_base;

  initial begin
    test_reset_counted();
    test_line();
    test_frame();
    test_mid_reset();
    test_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic test_reset_counted();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({d_x, d_y} !== 20'd0) begin
      errors++;
      $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", d_x, d_y);
    end
    checks++;
    if ({d_video_on, d_p_tick, d_hsync, d_vsync, d_hsync_d, d_vsync_d, d_line_start, d_frame_start} !== 8'b0011_1100) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00111100",
               {d_video_on, d_p_tick, d_hsync, d_vsync, d_hsync_d, d_vsync_d, d_line_start, d_frame_start});
    end
    checks++;
    if ({f_p_tick, f_hsync, f_vsync, f_hsync_d} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_fast_idle: got %b expected 0000", {f_p_tick, f_hsync, f_vsync, f_hsync_d});
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({d_video_on, d_hsync, d_vsync, d_x, d_y} !== {3'b111, 20'd0}) begin
      errors++;
      $display("FAIL release_cycle0: got von=%b hs=%b vs=%b x=%0d y=%0d expected 1 1 1 0 0",
               d_video_on, d_hsync, d_vsync, d_x, d_y);
    end
    checks++;
    if (f_p_tick !== 1'b1) begin
      errors++;
      $display("FAIL release_fast_tick: got %b expected 1", f_p_tick);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (d_p_tick !== 1'(c == 3)) begin
        errors++;
        $display("FAIL release_p_tick: cycle %0d got %b expected %b", c, d_p_tick, 1'(c == 3));
      end
      checks++;
      if (d_x !== ((c == 4) ? 10'd1 : 10'd0)) begin
        errors++;
        $display("FAIL release_x: cycle %0d got %0d expected %0d", c, d_x, (c == 4) ? 1 : 0);
      end
      tick();
    end
  endtask

endmodule
